// File: rtl/wb_bus_watchdog.sv
// Wishbone bus watchdog between the CPU master port and the interconnect: forwards accesses,
// terminates hung or erroring ones with FAULT_DATA, and logs faults in a small control slave.
module wb_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8,
    parameter logic [31:0] FAULT_DATA     = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbc_adr_i,
    input  logic [31:0] wbc_dat_i,
    input  logic        wbc_we_i,
    input  logic        wbc_cyc_i,
    input  logic        wbc_stb_i,
    output logic [31:0] wbc_dat_o,
    output logic        wbc_ack_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req;
    logic             rec_err, rec_to;

    logic             fault_q, fault_d;
    logic             kind_q, kind_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       count_base;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic             wbc_ack_q;
    logic [31:0]      wbc_dat_q;
    logic             wbc_req;
    logic             clr;
    logic [31:0]      status_w;
    logic             unused_wbc_dat;

    assign wbm_adr_o = wbs_adr_i;
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_sel_o = wbs_sel_i;
    assign wbm_we_o  = wbs_we_i;

    assign req = wbs_cyc_i & wbs_stb_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wbm_cyc_o = wbs_cyc_i;
        wbm_stb_o = wbs_stb_i;
        wbs_ack_o = 1'b0;
        wbs_dat_o = wbm_dat_i;
        rec_err   = 1'b0;
        rec_to    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (wbm_err_i) begin
                        wbs_ack_o = 1'b1;
                        wbs_dat_o = FAULT_DATA;
                        rec_err   = 1'b1;
                    end else if (wbm_ack_i) begin
                        wbs_ack_o = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // A withdrawn request ends the wait silently; no ack may be given without stb.
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (wbm_err_i) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = FAULT_DATA;
                    rec_err   = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else if (wbm_ack_i) begin
                    wbs_ack_o = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = S_ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ABORT: begin
                wbm_cyc_o = 1'b0;
                wbm_stb_o = 1'b0;
                wbs_ack_o = req;
                wbs_dat_o = FAULT_DATA;
                rec_to    = 1'b1;
                state_d   = S_IDLE;
                cnt_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!wb_rst_ni) begin
            wbm_cyc_o = 1'b0;
            wbm_stb_o = 1'b0;
            wbs_ack_o = 1'b0;
            rec_err   = 1'b0;
            rec_to    = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wbc_req        = wbc_cyc_i & wbc_stb_i & ~wbc_ack_q;
    assign clr            = wbc_req & wbc_we_i & ~wbc_adr_i & wbc_dat_i[0];
    assign status_w       = {16'h0, count_q, 6'h0, kind_q, fault_q};
    assign unused_wbc_dat = ^wbc_dat_i[31:1];

    // Clear is applied first so a coincident fault record lands on a cleared log.
    always_comb begin
        fault_d      = fault_q;
        kind_d       = kind_q;
        fault_addr_d = fault_addr_q;
        count_base   = clr ? 8'h00 : count_q;
        count_d      = count_base;
        if (clr) begin
            fault_d = 1'b0;
            kind_d  = 1'b0;
        end
        if (rec_err | rec_to) begin
            fault_d      = 1'b1;
            kind_d       = rec_to;
            fault_addr_d = wbs_adr_i;
            count_d      = (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            fault_q      <= 1'b0;
            kind_q       <= 1'b0;
            count_q      <= '0;
            fault_addr_q <= '0;
            wbc_ack_q    <= 1'b0;
            wbc_dat_q    <= '0;
        end else begin
            fault_q      <= fault_d;
            kind_q       <= kind_d;
            count_q      <= count_d;
            fault_addr_q <= fault_addr_d;
            wbc_ack_q    <= wbc_cyc_i & wbc_stb_i & ~wbc_ack_q;
            if (wbc_req && !wbc_we_i) begin
                wbc_dat_q <= wbc_adr_i ? fault_addr_q : status_w;
            end
        end
    end

    assign wbc_ack_o = wbc_ack_q;
    assign wbc_dat_o = wbc_dat_q;
    assign irq_o     = fault_q;

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Directed bench for wb_bus_watchdog: a per-cycle reference model of the access/fault rules
// plus hand-computed literal checks for each scenario.
module tb_wb_bus_watchdog;

    localparam int unsigned TO   = 8;
    localparam logic [31:0] FDAT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbs_adr, wbs_dat, wbm_dat;
    logic [3:0]  wbs_sel;
    logic        wbs_we, wbs_cyc, wbs_stb, wbm_ack, wbm_err;
    logic        wbc_adr, wbc_we, wbc_cyc, wbc_stb;
    logic [31:0] wbc_dat;
    logic [31:0] wbs_dat_o, wbm_adr_o, wbm_dat_o, wbc_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbs_ack_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbc_ack_o, irq_o;

    int checks   = 0;
    int failures = 0;

    wb_bus_watchdog #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8),
        .FAULT_DATA(FDAT)
    ) dut (
        .wb_clk_i(clk),       .wb_rst_ni(rst_n),
        .wbs_adr_i(wbs_adr),  .wbs_dat_i(wbs_dat),   .wbs_sel_i(wbs_sel),
        .wbs_we_i(wbs_we),    .wbs_cyc_i(wbs_cyc),   .wbs_stb_i(wbs_stb),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o),  .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_dat_i(wbm_dat),  .wbm_ack_i(wbm_ack),   .wbm_err_i(wbm_err),
        .wbc_adr_i(wbc_adr),  .wbc_dat_i(wbc_dat),   .wbc_we_i(wbc_we),
        .wbc_cyc_i(wbc_cyc),  .wbc_stb_i(wbc_stb),
        .wbc_dat_o(wbc_dat_o), .wbc_ack_o(wbc_ack_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the access age in cycles decides the abort; the fault log is plain counters.
    int          m_age = 0;
    bit          m_fault = 0, m_kind = 0;
    int          m_count = 0;
    logic [31:0] m_faddr = '0;
    bit          m_wack = 0;
    logic [31:0] m_wdat = '0;

    always @(negedge clk) begin
        bit          rq, ab, e_ack, ev, wreq, clr;
        logic [31:0] e_dat;
        if (!rst_n) begin
            chk("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
            chk("rst_wbm_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("rst_wbm_stb", 32'(wbm_stb_o), 32'd0);
            chk("rst_wbc_ack", 32'(wbc_ack_o), 32'd0);
            chk("rst_wbc_dat", wbc_dat_o, 32'd0);
            chk("rst_irq", 32'(irq_o), 32'd0);
            m_age = 0; m_fault = 0; m_kind = 0; m_count = 0; m_faddr = '0;
            m_wack = 0; m_wdat = '0;
        end else begin
            rq    = wbs_cyc && wbs_stb;
            ab    = (m_age == TO + 1);
            e_ack = rq && (ab || wbm_err || wbm_ack);
            e_dat = (ab || wbm_err) ? FDAT : wbm_dat;
            chk("pass_adr", wbm_adr_o, wbs_adr);
            chk("pass_dat", wbm_dat_o, wbs_dat);
            chk("pass_sel_we", {27'd0, wbm_sel_o, wbm_we_o}, {27'd0, wbs_sel, wbs_we});
            chk("wbm_cyc", 32'(wbm_cyc_o), 32'(wbs_cyc && !ab));
            chk("wbm_stb", 32'(wbm_stb_o), 32'(wbs_stb && !ab));
            chk("wbs_ack", 32'(wbs_ack_o), 32'(e_ack));
            if (e_ack) chk("wbs_dat", wbs_dat_o, e_dat);
            chk("irq", 32'(irq_o), 32'(m_fault));
            chk("wbc_ack", 32'(wbc_ack_o), 32'(m_wack));
            if (m_wack) chk("wbc_dat", wbc_dat_o, m_wdat);

            ev   = ab || (rq && wbm_err);
            wreq = wbc_cyc && wbc_stb && !m_wack;
            clr  = wreq && wbc_we && !wbc_adr && wbc_dat[0];
            if (wreq && !wbc_we)
                m_wdat = wbc_adr ? m_faddr : {16'h0, 8'(m_count), 6'h0, m_kind, m_fault};
            if (clr) begin m_fault = 0; m_kind = 0; m_count = 0; end
            if (ev) begin
                m_fault = 1;
                m_kind  = ab;
                m_count = (m_count < 255) ? m_count + 1 : 255;
                m_faddr = wbs_adr;
            end
            m_wack = wbc_cyc && wbc_stb && !m_wack;
            m_age  = (ab || !rq || e_ack) ? 0 : m_age + 1;
        end
    end

    task automatic idle_cpu();
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbm_ack = 0; wbm_err = 0;
    endtask

    // Cycle index 0 is the cycle the request is first presented.
    task automatic cpu_access(input logic [31:0] adr, input logic we, input int ack_c,
                              input int err_c, input int max_c,
                              output int ack_at, output int low_at, output logic [31:0] rdat);
        ack_at = -1; low_at = -1; rdat = '0;
        wbs_adr = adr; wbs_we = we; wbs_dat = ~adr; wbs_sel = 4'hF;
        wbs_cyc = 1; wbs_stb = 1;
        for (int i = 0; i < max_c; i++) begin
            wbm_ack = (i == ack_c);
            wbm_err = (i == err_c);
            wbm_dat = 32'hA5A5_0000 + 32'(i);
            @(negedge clk);
            if (!wbm_cyc_o && low_at < 0) low_at = i;
            if (wbs_ack_o) begin ack_at = i; rdat = wbs_dat_o; end
            @(posedge clk); #1;
            if (ack_at >= 0) break;
        end
        idle_cpu();
    endtask

    task automatic wbc_xfer(input logic a, input logic we, input logic [31:0] wd,
                            output logic [31:0] d);
        int n;
        n = 0;
        wbc_adr = a; wbc_we = we; wbc_dat = wd; wbc_cyc = 1; wbc_stb = 1;
        do begin @(negedge clk); n++; end while (!wbc_ack_o && n < 4);
        chk("wbc_ack_seen", 32'(wbc_ack_o), 32'd1);
        d = wbc_dat_o;
        @(posedge clk); #1;
        wbc_cyc = 0; wbc_stb = 0; wbc_we = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          ack_at, low_at, bad;
        logic [31:0] rd, d;
        rst_n = 0; wbs_adr = '0; wbs_dat = '0; wbs_sel = '0; wbm_dat = '0;
        idle_cpu();
        wbc_adr = 0; wbc_we = 0; wbc_cyc = 0; wbc_stb = 0; wbc_dat = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Stray slave responses without a CPU strobe must be dropped.
        wbm_ack = 1; wbm_err = 1;
        @(posedge clk); #1;
        wbs_cyc = 1;
        @(posedge clk); #1;
        idle_cpu();
        wbc_xfer(0, 0, '0, d); chk("stray_status", d, 32'h0);

        // 1: slave acks on the third cycle
        cpu_access(32'h0000_0100, 0, 2, -1, 12, ack_at, low_at, rd);
        chk("t1_ack_at", 32'(ack_at), 32'd2);
        chk("t1_data", rd, 32'hA5A5_0002);
        wbc_xfer(0, 0, '0, d); chk("t1_status", d, 32'h0);

        // 2: no response -> abort
        cpu_access(32'h4000_0010, 0, -1, -1, 16, ack_at, low_at, rd);
        chk("t2_ack_at", 32'(ack_at), 32'd9);
        chk("t2_cyc_low_at", 32'(low_at), 32'd9);
        chk("t2_data", rd, 32'hDEAD_BEEF);
        wbc_xfer(1, 0, '0, d); chk("t2_fault_addr", d, 32'h4000_0010);
        wbc_xfer(0, 0, '0, d); chk("t2_status", d, 32'h0000_0103);
        chk("t2_irq", 32'(irq_o), 32'd1);

        // 3: err on a write
        wbc_xfer(0, 1, 32'h1, d);
        wbc_xfer(0, 0, '0, d); chk("t3_cleared", d, 32'h0);
        cpu_access(32'h4000_0020, 1, -1, 1, 12, ack_at, low_at, rd);
        chk("t3_ack_at", 32'(ack_at), 32'd1);
        chk("t3_data", rd, 32'hDEAD_BEEF);
        chk("t3_no_abort", 32'(low_at), 32'hFFFF_FFFF);
        wbc_xfer(0, 0, '0, d); chk("t3_status", d, 32'h0000_0101);
        cpu_access(32'h4000_0030, 0, -1, 0, 4, ack_at, low_at, rd);
        chk("t3b_ack_at", 32'(ack_at), 32'd0);
        wbc_xfer(0, 0, '0, d); chk("t3b_status", d, 32'h0000_0201);

        // 4: 300 timeouts saturate the count
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            cpu_access(32'h5000_0000 + 32'(k * 4), 0, -1, -1, 12, ack_at, low_at, rd);
            if (ack_at != 9 || rd != FDAT) bad++;
        end
        chk("t4_aborts", 32'(bad), 32'd0);
        wbc_xfer(0, 0, '0, d); chk("t4_status_sat", d, 32'h0000_FF03);
        wbc_xfer(1, 1, 32'h0, d);
        wbc_xfer(1, 0, '0, d); chk("t4_faddr_ro", d, 32'h5000_04AC);
        wbc_xfer(0, 1, 32'h1, d);
        wbc_xfer(0, 0, '0, d); chk("t4_status_clr", d, 32'h0);
        chk("t4_irq", 32'(irq_o), 32'd0);

        // 5: fault record and clear in the same cycle
        cpu_access(32'h6000_0000, 0, -1, 0, 4, ack_at, low_at, rd);
        wbs_adr = 32'h6000_0004; wbs_cyc = 1; wbs_stb = 1; wbm_err = 1;
        wbc_adr = 0; wbc_we = 1; wbc_dat = 32'h1; wbc_cyc = 1; wbc_stb = 1;
        @(negedge clk); chk("t5_ack", 32'(wbs_ack_o), 32'd1);
        @(posedge clk); #1;
        idle_cpu(); wbc_cyc = 0; wbc_stb = 0; wbc_we = 0;
        @(posedge clk); #1;
        wbc_xfer(0, 0, '0, d); chk("t5_status", d, 32'h0000_0101);

        // 6: reset pulse mid-access
        wbs_adr = 32'h0000_0300; wbs_we = 0; wbs_cyc = 1; wbs_stb = 1;
        repeat (3) @(posedge clk);
        #1 wbm_ack = 1; rst_n = 0;
        #1;
        chk("t6_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("t6_ack", 32'(wbs_ack_o), 32'd0);
        @(posedge clk); #1;
        idle_cpu();
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        cpu_access(32'h0000_0100, 0, 2, -1, 12, ack_at, low_at, rd);
        chk("t6_ack_at", 32'(ack_at), 32'd2);
        chk("t6_data", rd, 32'hA5A5_0002);
        wbc_xfer(0, 0, '0, d); chk("t6_status", d, 32'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
